alu_arbiter: RTL and testbench

Shares the single combinational `alu` instance between two requesters, such as the execute stage and a debug/host port. Each requester hands over a full ALU micro-op (`alu_ir`, `sr`, `tr`). The arbiter selects a requester round-robin, registers the operands onto the ALU inputs, captures `alu_dr` one cycle later, and returns the result to the requester that owns it. One operation is in flight at a time. The block sits between the requesters and the `alu` instance and is the only driver of the ALU inputs.

---
 rtl/alu_arbiter.sv | 82 ++++++++
 tb/tb_alu_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational alu between two requesters
module alu_arbiter #(
  parameter int W   = 32,
  parameter int IRW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [IRW-1:0] req0_ir,
  input  logic [W-1:0]   req0_sr,
  input  logic [W-1:0]   req0_tr,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [IRW-1:0] req1_ir,
  input  logic [W-1:0]   req1_sr,
  input  logic [W-1:0]   req1_tr,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [W-1:0]   rsp_dr,
  output logic [IRW-1:0] alu_ir,
  output logic [W-1:0]   alu_sr,
  output logic [W-1:0]   alu_tr,
  input  logic [W-1:0]   alu_dr,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last;
  logic   owner;
  logic   grant1;
  logic   accept;
  logic   rsp_hs;

  always_comb begin
    state_nxt  = state;
    // On a tie, the requester that was not served last wins.
    grant1     = req1_valid & (~req0_valid | ~last);
    accept     = (state == IDLE) & (req0_valid | req1_valid);
    req0_ready = (state == IDLE) & req0_valid & ~grant1;
    req1_ready = (state == IDLE) & grant1;
    rsp0_valid = (state == RESP) & ~owner;
    rsp1_valid = (state == RESP) & owner;
    rsp_hs     = owner ? rsp1_ready : rsp0_ready;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      last   <= 1'b1;
      owner  <= 1'b0;
      alu_ir <= '0;
      alu_sr <= '0;
      alu_tr <= '0;
      rsp_dr <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      // ALU inputs move only on accept so the combinational result stays put.
      if (accept) begin
        owner  <= grant1;
        last   <= grant1;
        alu_ir <= grant1 ? req1_ir : req0_ir;
        alu_sr <= grant1 ? req1_sr : req0_sr;
        alu_tr <= grant1 ? req1_tr : req0_tr;
      end
      if (state == EXEC) rsp_dr <= alu_dr;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural alu
module tb_alu_arbiter;

  localparam logic [15:0] Z_ADD = 16'h0001;
  localparam logic [15:0] Z_SUB = 16'h0002;
  localparam logic [15:0] Z_OR  = 16'h0003;
  localparam logic [15:0] Z_XOR = 16'h0004;
  localparam logic [15:0] Z_SRA = 16'h0005;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_ir, req0_sr, req0_tr, req1_ir, req1_sr, req1_tr;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_dr, alu_ir, alu_sr, alu_tr, alu_dr;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int model_last = 1;

  always #5 clk = ~clk;

  alu_arbiter #(.W(32), .IRW(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ir(req0_ir), .req0_sr(req0_sr), .req0_tr(req0_tr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ir(req1_ir), .req1_sr(req1_sr), .req1_tr(req1_tr),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_dr(rsp_dr), .alu_ir(alu_ir), .alu_sr(alu_sr), .alu_tr(alu_tr), .alu_dr(alu_dr), .busy(busy)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] ir, input logic [31:0] sr, input logic [31:0] tr);
    case (ir[31:16])
      Z_ADD:   return sr + tr;
      Z_SUB:   return tr - sr;
      Z_OR:    return sr | tr;
      Z_XOR:   return sr ^ tr;
      Z_SRA:   return $signed(tr) >>> ir[11:8];
      default: return sr & tr;
    endcase
  endfunction

  assign alu_dr = alu_fn(alu_ir, alu_sr, alu_tr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " rsp0_valid"}, rsp0_valid, 0);
    chk({tag, " rsp1_valid"}, rsp1_valid, 0);
    chk({tag, " alu_ir"}, alu_ir, 0);
    chk({tag, " alu_sr"}, alu_sr, 0);
    chk({tag, " alu_tr"}, alu_tr, 0);
    chk({tag, " rsp_dr"}, rsp_dr, 0);
    chk({tag, " req0_ready"}, req0_ready, 0);
    chk({tag, " req1_ready"}, req1_ready, 0);
  endtask

  task automatic set_req(input int n, input logic v, input logic [31:0] ir, input logic [31:0] sr, input logic [31:0] tr);
    if (n == 0) begin
      req0_valid = v; req0_ir = ir; req0_sr = sr; req0_tr = tr;
    end else begin
      req1_valid = v; req1_ir = ir; req1_sr = sr; req1_tr = tr;
    end
  endtask

  // One op from a single requester; the other stays idle. Checks 2-edge latency.
  task automatic run_op(input int n, input logic [31:0] ir, input logic [31:0] sr, input logic [31:0] tr,
                        input logic [31:0] exp, input string name);
    int cnt = 0;
    @(negedge clk);
    set_req(n, 1'b1, ir, sr, tr);
    #1;
    while (((n == 0) ? req0_ready : req1_ready) !== 1'b1 && cnt < 20) begin
      @(negedge clk); #1; cnt++;
    end
    chk({name, " ready"}, (n == 0) ? req0_ready : req1_ready, 1);
    @(posedge clk);
    @(negedge clk);
    set_req(n, 1'b0, ir, sr, tr);
    #1;
    chk({name, " ready pulse"}, (n == 0) ? req0_ready : req1_ready, 0);
    chk({name, " busy exec"}, busy, 1);
    chk({name, " no early rsp"}, rsp0_valid | rsp1_valid, 0);
    @(negedge clk); #1;
    chk({name, " rsp_valid"}, (n == 0) ? rsp0_valid : rsp1_valid, 1);
    chk({name, " other rsp_valid"}, (n == 0) ? rsp1_valid : rsp0_valid, 0);
    chk({name, " rsp_dr"}, rsp_dr, exp);
    model_last = n;
    @(posedge clk);
  endtask

  typedef struct {
    int          n;
    logic [31:0] ir;
    logic [31:0] sr;
    logic [31:0] tr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[6];
  int   g_id[8];
  int   g_cyc[8];

  initial begin
    vecs[0] = '{0, {Z_ADD, 16'h0}, 32'd1, 32'd2, 32'd3, "add"};
    vecs[1] = '{1, {Z_XOR, 16'h0}, 32'd15, 32'd5, 32'd10, "xor"};
    vecs[2] = '{0, {Z_ADD, 16'h0}, 32'hFFFF_FFFF, 32'd1, 32'd0, "add_wrap"};
    vecs[3] = '{1, {Z_SRA, 16'h0390}, 32'd0, -32'sd40, -32'sd5, "sra"};
    vecs[4] = '{0, {Z_OR, 16'h0}, 32'hF0, 32'h0F, 32'hFF, "or"};
    vecs[5] = '{1, {Z_SUB, 16'h0}, 32'd1, 32'd0, 32'hFFFF_FFFF, "sub_neg"};

    rst = 1'b1;
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_state("reset");
    rst = 1'b0;

    // Table-driven single ops
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].n, vecs[i].ir, vecs[i].sr, vecs[i].tr, vecs[i].exp, vecs[i].name);

    // Hold: ALU inputs keep the last op's payload while idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("hold alu_ir", alu_ir, {Z_SUB, 16'h0});
      chk("hold alu_sr", alu_sr, 32'd1);
      chk("hold alu_tr", alu_tr, 32'd0);
      chk("hold busy", busy, 0);
    end

    // Tie right after reset: requester 0 wins
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_last = 1;
    set_req(0, 1'b1, {Z_SUB, 16'h0}, 32'd3, 32'd5);
    set_req(1, 1'b1, {Z_OR, 16'h0}, 32'd1, 32'd8);
    #1;
    chk("tie req0_ready", req0_ready, 1);
    chk("tie req1_ready", req1_ready, 0);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    chk("tie rsp0_valid", rsp0_valid, 1);
    chk("tie rsp1_valid", rsp1_valid, 0);
    chk("tie rsp_dr 0", rsp_dr, 32'd2);
    @(negedge clk); #1;
    chk("tie req1_ready", req1_ready, 1);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("tie rsp1_valid", rsp1_valid, 1);
    chk("tie rsp_dr 1", rsp_dr, 32'd9);
    model_last = 1;
    @(posedge clk);

    // Fairness: both valid continuously for 8 grants
    begin
      int ng = 0;
      int cyc = 0;
      @(negedge clk);
      set_req(0, 1'b1, {Z_ADD, 16'h0}, 32'd10, 32'd20);
      set_req(1, 1'b1, {Z_SUB, 16'h0}, 32'd4, 32'd10);
      while (ng < 8 && cyc < 60) begin
        #1;
        if (req0_ready || req1_ready) begin
          g_id[ng] = req1_ready ? 1 : 0;
          g_cyc[ng] = cyc;
          ng++;
        end
        if (rsp0_valid) chk("fair rsp_dr 0", rsp_dr, 32'd30);
        if (rsp1_valid) chk("fair rsp_dr 1", rsp_dr, 32'd6);
        @(negedge clk);
        cyc++;
      end
      chk("fair grant count", ng, 8);
      chk("fair first grant", g_id[0], 1 - model_last);
      for (int i = 1; i < ng; i++) begin
        chk("fair alternate", g_id[i], 1 - g_id[i-1]);
        chk("fair period", g_cyc[i] - g_cyc[i-1], 3);
      end
      set_req(0, 1'b0, 0, 0, 0);
      set_req(1, 1'b0, 0, 0, 0);
      repeat (4) @(negedge clk);
      model_last = g_id[7];
    end

    // Backpressure on requester 1
    @(negedge clk);
    set_req(1, 1'b1, {Z_SRA, 16'h0390}, 32'd0, -32'sd40);
    rsp1_ready = 1'b0;
    #1;
    chk("bp req1_ready", req1_ready, 1);
    @(posedge clk); @(negedge clk);
    set_req(0, 1'b1, {Z_ADD, 16'h0}, 32'd7, 32'd8);
    set_req(1, 1'b1, {Z_OR, 16'h0}, 32'd1, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp rsp1_valid", rsp1_valid, 1);
      chk("bp rsp0_valid", rsp0_valid, 0);
      chk("bp rsp_dr", rsp_dr, 32'hFFFF_FFFB);
      chk("bp req0_ready", req0_ready, 0);
    end
    rsp1_ready = 1'b1;
    @(negedge clk); #1;
    chk("bp next grant req0", req0_ready, 1);
    chk("bp next grant not req1", req1_ready, 0);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk); #1;
    chk("bp req0 rsp_dr", rsp_dr, 32'd15);
    @(negedge clk); #1;
    chk("bp then req1", req1_ready, 1);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    chk("bp req1 rsp_dr", rsp_dr, 32'd3);
    model_last = 1;
    @(posedge clk);

    // Reset during EXEC drops the op
    @(negedge clk);
    set_req(0, 1'b1, {Z_XOR, 16'h0}, 32'd15, 32'd5);
    #1;
    chk("rx req0_ready", req0_ready, 1);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_state("rst exec");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("rx no rsp0", rsp0_valid, 0);
    end
    model_last = 1;
    run_op(0, {Z_XOR, 16'h0}, 32'd15, 32'd5, 32'd10, "rx reissue");

    // Randomized traffic against a transaction-level model
    begin
      logic        v[2];
      logic [31:0] pir[2], psr[2], ptr[2];
      int          out_owner = -1;
      int          age = 0;
      logic [31:0] out_exp = 0;
      logic        e0, e1, ev0, ev1, hs;
      v[0] = 0; v[1] = 0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
          if (!v[n] && $urandom_range(0, 1) == 1) begin
            v[n] = 1;
            pir[n] = {16'($urandom_range(1, 5)), 4'h0, 4'($urandom_range(0, 15)), 8'h00};
            psr[n] = $urandom;
            ptr[n] = $urandom;
          end
          set_req(n, v[n], pir[n], psr[n], ptr[n]);
        end
        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
        #1;
        e0 = 0; e1 = 0;
        if (out_owner < 0) begin
          if (v[0] && v[1]) begin
            if (model_last == 0) e1 = 1; else e0 = 1;
          end else begin
            e0 = v[0]; e1 = v[1];
          end
        end
        chk("rnd req0_ready", req0_ready, e0);
        chk("rnd req1_ready", req1_ready, e1);
        ev0 = (out_owner == 0) && (age >= 1);
        ev1 = (out_owner == 1) && (age >= 1);
        chk("rnd rsp0_valid", rsp0_valid, ev0);
        chk("rnd rsp1_valid", rsp1_valid, ev1);
        if (ev0 || ev1) chk("rnd rsp_dr", rsp_dr, out_exp);
        chk("rnd busy", busy, out_owner >= 0);
        hs = (ev0 && rsp0_ready) || (ev1 && rsp1_ready);
        @(posedge clk);
        if (hs) out_owner = -1;
        else if (out_owner >= 0) age++;
        if (e0 || e1) begin
          out_owner = e1 ? 1 : 0;
          model_last = out_owner;
          age = 0;
          out_exp = alu_fn(pir[out_owner], psr[out_owner], ptr[out_owner]);
          v[out_owner] = 0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
